// File: rtl/dense_sched.sv
// ---------------------------------------------------------------------------
// dense_sched -- sequencer for one fully connected (dense) layer pass.
//
// For every neuron i it issues one LOAD_BIAS, then one ACC per input j
// (x_addr = j, w_addr = j*nb_neurons + i), requests the activation unit,
// waits for its result and writes y[i]. The weight address is built
// incrementally, adding the latched nb_neurons once per ACC cycle, so no
// multiplier is needed. It wraps modulo 2^AW.
//
// Every output comes straight from a flop. The output flops are loaded
// from the next-state values, so each state's strobe appears on the first
// cycle the FSM sits in that state. A stall sampled at a clock edge holds
// the sequencer and blanks the strobes for the following cycle. The
// operation already on the bus when stall rose counts as accepted, and the
// addresses keep their values during the stall.
//
// Ports
//   clk        in   single clock, rising edge
//   rst        in   synchronous active-high reset, highest priority
//   start      in   begin a pass (sampled only in IDLE)
//   nb_input   in   [NW] input vector length, latched on start
//   nb_neurons in   [NW] neuron count / weight stride, latched on start
//   stall      in   datapath backpressure (BIAS, ACC, ACT_REQ, WB only)
//   act_done   in   activation result ready (looked at only in ACT_WAIT)
//   busy       out  high in every state except IDLE
//   done       out  one-cycle pulse at the end of a pass
//   mac_op     out  [2] 00 NOP, 01 LOAD_BIAS, 10 ACC
//   mac_last   out  high with the final ACC of a neuron
//   b_addr     out  [NW] bias index i
//   x_addr     out  [NW] input index j
//   w_addr     out  [AW] weight index j*nb_neurons+i
//   act_start  out  one-cycle activation request
//   y_we       out  output vector write strobe
//   y_addr     out  [NW] output index i
// ---------------------------------------------------------------------------
module dense_sched #(
  parameter int AW = 16,
  parameter int NW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [NW-1:0] nb_input,
  input  logic [NW-1:0] nb_neurons,
  input  logic          stall,
  input  logic          act_done,
  output logic          busy,
  output logic          done,
  output logic [1:0]    mac_op,
  output logic          mac_last,
  output logic [NW-1:0] b_addr,
  output logic [NW-1:0] x_addr,
  output logic [AW-1:0] w_addr,
  output logic          act_start,
  output logic          y_we,
  output logic [NW-1:0] y_addr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BIAS,
    S_ACC,
    S_ACT_REQ,
    S_ACT_WAIT,
    S_WB,
    S_DONE
  } state_t;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_BIAS = 2'b01;
  localparam logic [1:0] OP_ACC  = 2'b10;

  // Sequencer state and counters
  state_t        r_state, w_state_nxt;
  logic [NW-1:0] r_i, w_i_nxt;
  logic [NW-1:0] r_j, w_j_nxt;
  logic [AW-1:0] r_w, w_w_nxt;
  logic [NW-1:0] r_nbi, w_nbi_nxt;
  logic [NW-1:0] r_nbn, w_nbn_nxt;
  logic          w_hold;

  // Registered outputs and their next values
  logic          r_busy, w_busy_nxt;
  logic          r_done, w_done_nxt;
  logic [1:0]    r_mac_op, w_mac_op_nxt;
  logic          r_mac_last, w_mac_last_nxt;
  logic [NW-1:0] r_b_addr, w_b_addr_nxt;
  logic [NW-1:0] r_x_addr, w_x_addr_nxt;
  logic [AW-1:0] r_w_addr, w_w_addr_nxt;
  logic          r_act_start, w_act_start_nxt;
  logic          r_y_we, w_y_we_nxt;
  logic [NW-1:0] r_y_addr, w_y_addr_nxt;

  logic [NW-1:0] w_i_inc;
  logic [NW-1:0] w_i_last;
  logic [NW-1:0] w_j_last;

  assign w_i_inc  = r_i + NW'(1);
  assign w_i_last = r_nbn - NW'(1);
  assign w_j_last = r_nbi - NW'(1);

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before the case so no path
    // leaves it unassigned; otherwise synthesis would infer a latch.
    w_state_nxt = r_state;
    w_i_nxt     = r_i;
    w_j_nxt     = r_j;
    w_w_nxt     = r_w;
    w_nbi_nxt   = r_nbi;
    w_nbn_nxt   = r_nbn;
    w_hold      = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_nbi_nxt   = nb_input;
          w_nbn_nxt   = nb_neurons;
          w_i_nxt     = '0;
          w_j_nxt     = '0;
          w_w_nxt     = '0;
          w_state_nxt = (nb_neurons != '0) ? S_BIAS : S_DONE;
        end
      end
      S_BIAS: begin
        if (stall) begin
          w_hold = 1'b1;
        end else begin
          w_j_nxt     = '0;
          w_state_nxt = (r_nbi != '0) ? S_ACC : S_ACT_REQ;
        end
      end
      S_ACC: begin
        if (stall) begin
          w_hold = 1'b1;
        end else if (r_j == w_j_last) begin
          w_state_nxt = S_ACT_REQ;
        end else begin
          w_j_nxt = r_j + NW'(1);
          w_w_nxt = r_w + AW'(r_nbn);
        end
      end
      S_ACT_REQ: begin
        if (stall) w_hold = 1'b1;
        else       w_state_nxt = S_ACT_WAIT;
      end
      S_ACT_WAIT: begin
        // stall is not looked at here, so act_done always wins
        if (act_done) w_state_nxt = S_WB;
      end
      S_WB: begin
        if (stall) begin
          w_hold = 1'b1;
        end else if (r_i == w_i_last) begin
          w_state_nxt = S_DONE;
        end else begin
          w_i_nxt     = w_i_inc;
          w_j_nxt     = '0;
          w_w_nxt     = AW'(w_i_inc);
          w_state_nxt = S_BIAS;
        end
      end
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Output decode: values loaded into the output flops at the same edge
  // that moves the FSM into the state they belong to.
  // ---------------------------------------------------------------------
  always_comb begin
    w_busy_nxt      = (w_state_nxt != S_IDLE);
    w_done_nxt      = (w_state_nxt == S_DONE);
    w_mac_op_nxt    = OP_NOP;
    w_mac_last_nxt  = 1'b0;
    w_act_start_nxt = 1'b0;
    w_y_we_nxt      = 1'b0;
    w_b_addr_nxt    = r_b_addr;
    w_x_addr_nxt    = r_x_addr;
    w_w_addr_nxt    = r_w_addr;
    w_y_addr_nxt    = r_y_addr;

    if (!w_hold) begin
      unique case (w_state_nxt)
        S_BIAS: begin
          w_mac_op_nxt = OP_BIAS;
          w_b_addr_nxt = w_i_nxt;
        end
        S_ACC: begin
          w_mac_op_nxt   = OP_ACC;
          w_mac_last_nxt = (w_j_nxt == w_j_last);
          w_x_addr_nxt   = w_j_nxt;
          w_w_addr_nxt   = w_w_nxt;
        end
        S_ACT_REQ: w_act_start_nxt = 1'b1;
        S_WB: begin
          w_y_we_nxt   = 1'b1;
          w_y_addr_nxt = w_i_nxt;
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments here so every flop samples the
    // values from before this edge, independent of statement order.
    if (rst) begin
      r_state     <= S_IDLE;
      r_i         <= '0;
      r_j         <= '0;
      r_w         <= '0;
      r_nbi       <= '0;
      r_nbn       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_mac_op    <= OP_NOP;
      r_mac_last  <= 1'b0;
      r_b_addr    <= '0;
      r_x_addr    <= '0;
      r_w_addr    <= '0;
      r_act_start <= 1'b0;
      r_y_we      <= 1'b0;
      r_y_addr    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_i         <= w_i_nxt;
      r_j         <= w_j_nxt;
      r_w         <= w_w_nxt;
      r_nbi       <= w_nbi_nxt;
      r_nbn       <= w_nbn_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_mac_op    <= w_mac_op_nxt;
      r_mac_last  <= w_mac_last_nxt;
      r_b_addr    <= w_b_addr_nxt;
      r_x_addr    <= w_x_addr_nxt;
      r_w_addr    <= w_w_addr_nxt;
      r_act_start <= w_act_start_nxt;
      r_y_we      <= w_y_we_nxt;
      r_y_addr    <= w_y_addr_nxt;
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign mac_op    = r_mac_op;
  assign mac_last  = r_mac_last;
  assign b_addr    = r_b_addr;
  assign x_addr    = r_x_addr;
  assign w_addr    = r_w_addr;
  assign act_start = r_act_start;
  assign y_we      = r_y_we;
  assign y_addr    = r_y_addr;

endmodule

// File: doc/dense_sched.md
DENSE_SCHED -- requirements
Module: dense_sched

Interface
REQ-001 SHALL have parameter AW, default 16, meaning width of weight address.
REQ-002 SHALL have parameter NW, default 8, meaning width of input/neuron counts and indices.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port start  input  1  begin one dense-layer pass; sampled only in IDLE.
REQ-006 SHALL have port nb_input  input  NW  input vector length; latched when start is accepted.
REQ-007 SHALL have port nb_neurons  input  NW  output count and weight stride; latched when start is accepted.
REQ-008 SHALL have port stall  input  1  datapath backpressure; freezes the sequencer.
REQ-009 SHALL have port act_done  input  1  activation unit result ready (tansig/sigmoid).
REQ-010 SHALL have port busy  output  1  high in every state except IDLE.
REQ-011 SHALL have port done  output  1  one-cycle pulse at end of pass.
REQ-012 SHALL have port mac_op  output  2  00 NOP, 01 LOAD_BIAS, 10 ACC, 11 unused.
REQ-013 SHALL have port mac_last  output  1  high with the final ACC of a neuron.
REQ-014 SHALL have port b_addr  output  NW  bias index, equal to the current neuron i.
REQ-015 SHALL have port x_addr  output  NW  input index j.
REQ-016 SHALL have port w_addr  output  AW  weight index j*nb_neurons+i.
REQ-017 SHALL have port act_start  output  1  one-cycle request to the activation unit.
REQ-018 SHALL have port y_we  output  1  write strobe for the output vector.
REQ-019 SHALL have port y_addr  output  NW  output index i.

Function
REQ-020 SHALL implement FSM states IDLE, BIAS, ACC, ACT_REQ, ACT_WAIT, WB, DONE.
REQ-021 SHALL go from IDLE with start=1 to BIAS when latched nb_neurons!=0, else to DONE; i=0, j=0.
REQ-022 SHALL in BIAS drive mac_op=01 and b_addr=i for one cycle, then go to ACC if nb_input!=0, else to ACT_REQ.
REQ-023 SHALL in ACC drive mac_op=10 with x_addr=j and w_addr=j*nb_neurons+i for one cycle per j, for j=0..nb_input-1.
REQ-024 SHALL in ACC assert mac_last when j=nb_input-1 and then go to ACT_REQ.
REQ-025 SHALL generate w_addr by adding the latched nb_neurons each ACC cycle, starting from i; no multiplier.
REQ-026 SHALL make w_addr wrap modulo 2^AW; no overflow flag.
REQ-027 SHALL assert act_start for exactly one cycle in ACT_REQ, then go to ACT_WAIT.
REQ-028 SHALL hold in ACT_WAIT until act_done=1, then go to WB.
REQ-029 SHALL sample act_done only in ACT_WAIT and ignore it in all other states.
REQ-030 SHALL in WB assert y_we with y_addr=i for one cycle.
REQ-031 SHALL leave WB for DONE if i=nb_neurons-1, else for BIAS with i+1 and j=0.
REQ-032 SHALL in DONE assert done for one cycle and return to IDLE; busy stays high in DONE.
REQ-033 SHALL, while stall=1 in BIAS, ACC, ACT_REQ or WB, hold state, i, j and w_addr unchanged.
REQ-034 SHALL, under stall=1, force mac_op=00, mac_last=0, act_start=0 and y_we=0; addresses keep their values.
REQ-035 SHALL ignore stall in IDLE, ACT_WAIT and DONE.
REQ-036 SHALL have act_done taking priority over stall in ACT_WAIT.
REQ-037 SHALL ignore start while busy=1 and leave the latched configuration unchanged.
REQ-038 SHALL make mac_op, mac_last, act_start, y_we, done and busy registered outputs, with no combinational path from inputs.
REQ-039 SHALL drive strobes 0 and hold addresses in states that do not use them.
REQ-040 SHALL take, per neuron with no stall, 1 + nb_input + 1 + W + 1 cycles, where W>=1 is the ACT_WAIT cycles including the act_done cycle.

Reset
REQ-041 SHALL, with rst=1 at a clock edge, enter IDLE from any state, including mid-pass.
REQ-042 SHALL on reset clear i, j, w_addr, b_addr, x_addr, y_addr and the latched nb_input and nb_neurons to 0.
REQ-043 SHALL on reset drive busy=0, done=0, mac_op=00, mac_last=0, act_start=0 and y_we=0.
REQ-044 SHALL give rst priority over start, stall and act_done.
REQ-045 SHALL not resume an aborted pass after reset; a new start is required.

Verification
REQ-046 SHALL verify nb_input=42, nb_neurons=24, act_done 2 cycles after act_start, no stall -> 47 cycles/neuron, done exactly 1129 cycles after start, 24 y_we pulses at y_addr 0..23.
REQ-047 SHALL verify in that pass, neuron 1 -> w_addr 1,25,49,...,985 and mac_last only at w_addr=985.
REQ-048 SHALL verify nb_input=0, nb_neurons=3 -> BIAS,ACT_REQ,ACT_WAIT,WB per neuron with no mac_op=10 and 3 y_we pulses.
REQ-049 SHALL verify nb_neurons=0 -> done 1 cycle after start, no mac_op, act_start or y_we activity.
REQ-050 SHALL verify stall high 5 cycles at ACC j=10 -> mac_op=00 for 5 cycles, x_addr stays 10, pass 5 cycles longer; start pulsed mid-pass ignored.
REQ-051 SHALL verify rst asserted in ACT_WAIT of neuron 7 -> next cycle IDLE with all outputs at reset values; a later act_done does not cause y_we.
